// File: rtl/score_tracker_pkg.sv
// score_tracker_pkg: shared game-state type and BCD constants for score_tracker
package score_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, LOSE} game_state_t;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;
endpackage

// File: rtl/score_tracker_bcd_digit.sv
// bcd_digit: one BCD score digit that counts 0..9 and carries out on 9->0
module bcd_digit
    import score_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_in,
    input  logic             clr,
    output logic [BCD_W-1:0] digit,
    output logic             carry_out
);
    logic [BCD_W-1:0] digit_q;
    assign digit     = digit_q;
    assign carry_out = inc_in & (digit_q == BCD_NINE);
    // Digit register: clear wins, otherwise count up with wrap at nine
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            digit_q <= '0;
        else if (clr)
            digit_q <= '0;
        else if (inc_in)
            digit_q <= carry_out ? '0 : digit_q + 1'b1;
    end
endmodule

// File: rtl/score_tracker.sv
// score_tracker: N-digit BCD score, miss counter and IDLE/PLAY/LOSE game FSM.
// Optional high-score register and new_record flag with SCORE_TRACKER_HIGH_SCORE_EN.
module score_tracker
    import score_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int MAX_MISSES = 3,
    parameter int MISS_W     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        correct_whack,
    input  logic                        missed_mole,
    output logic [BCD_W*NUM_DIGITS-1:0] score_bcd,
    output logic [MISS_W-1:0]           misses,
    output logic                        playing,
    output logic                        game_lose,
    output logic                        score_max
`ifdef SCORE_TRACKER_HIGH_SCORE_EN
    ,
    output logic [BCD_W*NUM_DIGITS-1:0] high_score,
    output logic                        new_record
`endif
);
    game_state_t       state_q;
    logic [MISS_W-1:0] misses_q, misses_d;
    logic              start_q, hit_q, miss_q;
    logic              start_ev, hit_ev, miss_ev, clr, lose_edge;
    logic [NUM_DIGITS:0]   carry;
    logic [NUM_DIGITS-1:0] is_nine;

    assign start_ev  = start & ~start_q;
    assign hit_ev    = correct_whack & ~hit_q;
    assign miss_ev   = missed_mole & ~miss_q;
    assign clr       = start_ev & (state_q != PLAY);
    assign misses_d  = misses_q + 1'b1;
    assign lose_edge = (state_q == PLAY) & miss_ev & (misses_d == MISS_W'(MAX_MISSES));
    assign playing   = (state_q == PLAY);
    assign game_lose = (state_q == LOSE);
    assign misses    = misses_q;
    assign score_max = &is_nine;
    // Saturation: the chain is never fed once every digit shows nine
    assign carry[0]  = hit_ev & playing & ~score_max;

    genvar i;
    generate
        for (i = 0; i < NUM_DIGITS; i++) begin : g_digit
            bcd_digit u_digit (
                .clk      (clk),
                .rst      (rst),
                .inc_in   (carry[i]),
                .clr      (clr),
                .digit    (score_bcd[BCD_W*i +: BCD_W]),
                .carry_out(carry[i+1])
            );
            assign is_nine[i] = (score_bcd[BCD_W*i +: BCD_W] == BCD_NINE);
        end
    endgenerate

    // Game FSM, miss counter and input edge-detect history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            misses_q <= '0;
            start_q  <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            start_q <= start;
            hit_q   <= correct_whack;
            miss_q  <= missed_mole;
            if (state_q == PLAY) begin
                if (miss_ev) begin
                    misses_q <= misses_d;
                    if (lose_edge)
                        state_q <= LOSE;
                end
            end else if (start_ev) begin
                state_q  <= PLAY;
                misses_q <= '0;
            end
        end
    end

`ifdef SCORE_TRACKER_HIGH_SCORE_EN
    logic [BCD_W*NUM_DIGITS-1:0] score_nxt, high_score_q;
    logic                        new_record_q;

    generate
        for (i = 0; i < NUM_DIGITS; i++) begin : g_next
            assign score_nxt[BCD_W*i +: BCD_W] = carry[i] ?
                (is_nine[i] ? '0 : score_bcd[BCD_W*i +: BCD_W] + 1'b1) :
                score_bcd[BCD_W*i +: BCD_W];
        end
    endgenerate

    assign high_score = high_score_q;
    assign new_record = new_record_q;

    // Best final score; packed BCD compares exactly like digit-wise MSD-first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_score_q <= '0;
            new_record_q <= 1'b0;
        end else if (lose_edge && (score_nxt > high_score_q)) begin
            high_score_q <= score_nxt;
            new_record_q <= 1'b1;
        end else if (clr) begin
            new_record_q <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_score_tracker.sv
// tb_score_tracker: scoreboard bench for score_tracker against a behavioural game model
module tb_score_tracker;
    localparam int ND   = 2;
    localparam int MM   = 3;
    localparam int MW   = 4;
    localparam int SW   = 4 * ND;
    localparam int SMAX = 10 ** ND - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          correct_whack = 1'b0;
    logic          missed_mole = 1'b0;
    logic [SW-1:0] score_bcd;
    logic [MW-1:0] misses;
    logic          playing, game_lose, score_max;
`ifdef SCORE_TRACKER_HIGH_SCORE_EN
    logic [SW-1:0] high_score;
    logic          new_record;
`endif

    score_tracker #(.NUM_DIGITS(ND), .MAX_MISSES(MM), .MISS_W(MW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .correct_whack(correct_whack),
        .missed_mole  (missed_mole),
        .score_bcd    (score_bcd),
        .misses       (misses),
        .playing      (playing),
        .game_lose    (game_lose),
        .score_max    (score_max)
`ifdef SCORE_TRACKER_HIGH_SCORE_EN
        ,
        .high_score   (high_score),
        .new_record   (new_record)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int score;
        int miss;
        bit play;
        bit lose;
        bit smax;
        int hs;
        bit nr;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   m_state, m_score, m_miss, m_hs;
    bit   m_nr, p_st, p_h, p_m;

    function automatic logic [SW-1:0] to_bcd(input int v);
        logic [SW-1:0] r;
        int            x;
        x = v;
        for (int k = 0; k < ND; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_state = 0; m_score = 0; m_miss = 0; m_hs = 0;
        m_nr = 0; p_st = 0; p_h = 0; p_m = 0;
    endtask

    task automatic step(input bit s, input bit h, input bit m);
        bit   se, he, me;
        exp_t e;
        start = s; correct_whack = h; missed_mole = m;
        se = s && !p_st; he = h && !p_h; me = m && !p_m;
        p_st = s; p_h = h; p_m = m;
        if (m_state == 1) begin
            if (he && m_score < SMAX) m_score++;
            if (me) begin
                m_miss++;
                if (m_miss == MM) begin
                    m_state = 2;
                    if (m_score > m_hs) begin
                        m_hs = m_score;
                        m_nr = 1;
                    end
                end
            end
        end else if (se) begin
            m_state = 1; m_score = 0; m_miss = 0; m_nr = 0;
        end
        sb.push_back('{m_score, m_miss, m_state == 1, m_state == 2, m_score == SMAX, m_hs, m_nr});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("score", 32'(score_bcd), 32'(to_bcd(e.score)));
        check("misses", 32'(misses), 32'(e.miss));
        check("playing", 32'(playing), 32'(e.play));
        check("game_lose", 32'(game_lose), 32'(e.lose));
        check("score_max", 32'(score_max), 32'(e.smax));
`ifdef SCORE_TRACKER_HIGH_SCORE_EN
        check("high_score", 32'(high_score), 32'(to_bcd(e.hs)));
        check("new_record", 32'(new_record), 32'(e.nr));
`endif
    endtask

    task automatic hits(input int n);
        repeat (n) begin
            step(0, 1, 0);
            step(0, 0, 0);
        end
    endtask

    task automatic miss_pulses(input int n);
        repeat (n) begin
            step(0, 0, 1);
            step(0, 0, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_score", 32'(score_bcd), 32'h0);
        check("rst_misses", 32'(misses), 32'h0);
        check("rst_playing", 32'(playing), 32'h0);
        check("rst_lose", 32'(game_lose), 32'h0);
        check("rst_max", 32'(score_max), 32'h0);
        rst = 1'b0;
        step(1, 0, 0);
        step(0, 0, 0);
        hits(12);
        check("twelve_hits", 32'(score_bcd), 32'h12);
        repeat (10) step(0, 1, 0);
        step(0, 0, 0);
        check("held_hit", 32'(score_bcd), 32'h13);
        miss_pulses(3);
        check("lose_after_3", 32'(game_lose), 32'h1);
        hits(2);
        check("frozen_score", 32'(score_bcd), 32'h13);
        step(1, 0, 0);
        step(0, 0, 0);
        check("restart_score", 32'(score_bcd), 32'h0);
        hits(101);
        check("saturated", 32'(score_bcd), 32'h99);
        check("sat_max", 32'(score_max), 32'h1);
        miss_pulses(3);
        step(1, 0, 0);
        step(0, 0, 0);
        hits(5);
        miss_pulses(2);
        step(0, 1, 1);
        check("hit_miss_score", 32'(score_bcd), 32'h06);
        check("hit_miss_misses", 32'(misses), 32'h3);
        check("hit_miss_lose", 32'(game_lose), 32'h1);
        step(0, 0, 0);
        step(1, 1, 0);
        check("start_wins", 32'(score_bcd), 32'h0);
        step(0, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        hits(45);
        check("score45", 32'(score_bcd), 32'h45);
        #3;
        rst = 1'b1;
        start = 1'b1;
        #1;
        check("async_score", 32'(score_bcd), 32'h0);
        check("async_misses", 32'(misses), 32'h0);
        check("async_playing", 32'(playing), 32'h0);
        check("async_lose", 32'(game_lose), 32'h0);
        #2;
        rst = 1'b0;
        model_reset();
        step(1, 0, 0);
        check("start_after_rst", 32'(playing), 32'h1);
        step(0, 0, 0);
        hits(7);
        miss_pulses(3);
`ifdef SCORE_TRACKER_HIGH_SCORE_EN
        check("hs_game1", 32'(high_score), 32'h07);
        check("nr_game1", 32'(new_record), 32'h1);
`endif
        step(1, 0, 0);
        step(0, 0, 0);
        hits(5);
        miss_pulses(3);
`ifdef SCORE_TRACKER_HIGH_SCORE_EN
        check("hs_game2", 32'(high_score), 32'h07);
        check("nr_game2", 32'(new_record), 32'h0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
